// File: rtl/mmio_responder_if.sv
// CPU-side memory bus plus the TX ready/valid port served by mmio_responder.
interface mmio_responder_if;
  logic [31:0] addr;
  logic        wr;
  logic [31:0] wdata;
  logic        hit;
  logic [31:0] rdata;
  logic        irq;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  modport master (
    output addr, wr, wdata, tx_ready,
    input  hit, rdata, irq, tx_data, tx_valid
  );

  modport slave (
    input  addr, wr, wdata, tx_ready,
    output hit, rdata, irq, tx_data, tx_valid
  );
endinterface

// File: rtl/mmio_responder.sv
// 32-byte MMIO window: CTRL/STATUS, compare timer and a byte TX FIFO with ready/valid drain.
// Timer (COUNT, COMPARE, MATCH, irq) is built only when MMIO_TIMER_EN is defined.
module mmio_responder #(
  parameter logic [31:0] BASE_ADDR  = 32'hFFFF_FF00,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input logic            clk,
  input logic            reset,
  mmio_responder_if.slave bus
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

  localparam logic [2:0] RegCtrl    = 3'd0;
  localparam logic [2:0] RegStatus  = 3'd1;
  localparam logic [2:0] RegCount   = 3'd2;
  localparam logic [2:0] RegCompare = 3'd3;
  localparam logic [2:0] RegTxData  = 3'd4;

  logic [2:0] sel;
  logic       wr_en, rd_en;
  logic       unused_addr;

  assign bus.hit     = (bus.addr[31:5] == BASE_ADDR[31:5]);
  assign sel         = bus.addr[4:2];
  assign wr_en       = bus.hit && bus.wr;
  assign rd_en       = bus.hit && !bus.wr;
  assign unused_addr = ^bus.addr[1:0];

  // ---------------------------------------------------------------- timer
  logic        ten_q, match_q;
  logic [31:0] count_q, compare_q;
  logic        ien_q, ien_d;

`ifdef MMIO_TIMER_EN
  logic        ten_d, match_d;
  logic [31:0] count_d, compare_d;

  always_comb begin
    ten_d     = ten_q;
    compare_d = compare_q;
    count_d   = count_q;
    if (wr_en && sel == RegCtrl)    ten_d     = bus.wdata[0];
    if (wr_en && sel == RegCompare) compare_d = bus.wdata;
    // A COUNT write replaces that cycle's increment.
    if (wr_en && sel == RegCount)   count_d   = bus.wdata;
    else if (ten_q)                 count_d   = count_q + 32'd1;
    // Set beats write-1-clear.
    match_d = (match_q & ~(wr_en && sel == RegStatus && bus.wdata[0]))
            | (ten_q && count_q == compare_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ten_q     <= 1'b0;
      match_q   <= 1'b0;
      count_q   <= '0;
      compare_q <= '0;
    end else begin
      ten_q     <= ten_d;
      match_q   <= match_d;
      count_q   <= count_d;
      compare_q <= compare_d;
    end
  end

  assign bus.irq = match_q & ien_q;
`else
  logic unused_wdata;

  assign ten_q        = 1'b0;
  assign match_q      = 1'b0;
  assign count_q      = '0;
  assign compare_q    = '0;
  assign bus.irq      = 1'b0;
  assign unused_wdata = ^bus.wdata[31:8];
`endif

  // ---------------------------------------------------------------- TX FIFO
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            full, empty, pop, push_req, push, ovf_set;
  logic            ovf_q, ovf_d;

  assign full     = (cnt_q == CntW'(FIFO_DEPTH));
  assign empty    = (cnt_q == '0);
  assign pop      = !empty && bus.tx_ready;
  assign push_req = wr_en && sel == RegTxData;
  // A pop in the same cycle frees the slot a full-FIFO push needs.
  assign push     = push_req && (!full || pop);
  assign ovf_set  = push_req && full && !pop;

  assign cnt_d        = cnt_q + CntW'(push) - CntW'(pop);
  assign bus.tx_valid = !empty;
  assign bus.tx_data  = empty ? 8'h00 : mem_q[rptr_q];

  always_comb begin
    ien_d = ien_q;
    if (wr_en && sel == RegCtrl) ien_d = bus.wdata[1];
    ovf_d = (ovf_q & ~(wr_en && sel == RegStatus && bus.wdata[3])) | ovf_set;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      ien_q  <= 1'b0;
    end else begin
      if (push) begin
        mem_q[wptr_q] <= bus.wdata[7:0];
        wptr_q        <= wptr_q + PtrW'(1);
      end
      if (pop) rptr_q <= rptr_q + PtrW'(1);
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      ien_q <= ien_d;
    end
  end

  // ---------------------------------------------------------------- read path
  logic [31:0] rdata_d, rdata_q;

  always_comb begin
    rdata_d = '0;
    if (rd_en) begin
      case (sel)
        RegCtrl:    rdata_d = {30'd0, ien_q, ten_q};
        RegStatus:  rdata_d = {24'd0, 4'(cnt_q), ovf_q, empty, full, match_q};
        RegCount:   rdata_d = count_q;
        RegCompare: rdata_d = compare_q;
        default:    rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rdata_q <= '0;
    else        rdata_q <= rdata_d;
  end

  assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_mmio_responder.sv
// Directed self-checking bench for mmio_responder; timer checks follow MMIO_TIMER_EN.
module tb_mmio_responder;

  localparam logic [31:0] BASE = 32'hFFFF_FF00;
  localparam logic [31:0] IDLE = 32'h0000_0000;

  logic clk = 1'b0;
  logic reset;
  int   tests_run = 0;
  int   tests_failed = 0;

  mmio_responder_if bus ();

  mmio_responder #(
    .BASE_ADDR  (BASE),
    .FIFO_DEPTH (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  // Called at a negedge; the access edge is the next posedge.
  task automatic wr_reg(input logic [4:0] off, input logic [31:0] data);
    bus.addr  = BASE + 32'(off);
    bus.wr    = 1'b1;
    bus.wdata = data;
    @(negedge clk);
    bus.wr    = 1'b0;
    bus.addr  = IDLE;
    bus.wdata = '0;
  endtask

  task automatic rd_reg(input logic [4:0] off, output logic [31:0] data);
    bus.addr = BASE + 32'(off);
    bus.wr   = 1'b0;
    @(negedge clk);
    data     = bus.rdata;
    bus.addr = IDLE;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    reset = 1'b0;
    bus.addr = IDLE; bus.wr = 1'b0; bus.wdata = '0; bus.tx_ready = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++;
    if (bus.rdata !== 32'h0) begin tests_failed++;
      $display("FAIL reset_rdata: got %h want %h", bus.rdata, 32'h0); end
    tests_run++;
    if (bus.irq !== 1'b0 || bus.tx_valid !== 1'b0 || bus.tx_data !== 8'h00) begin tests_failed++;
      $display("FAIL reset_outputs: got irq=%b valid=%b data=%h want 0 0 00",
               bus.irq, bus.tx_valid, bus.tx_data); end
    reset = 1'b1;
    @(negedge clk);
    rd_reg(5'h04, v);
    tests_run++;
    if (v !== 32'h0000_0004) begin tests_failed++;
      $display("FAIL reset_status: got %h want %h", v, 32'h4); end
  endtask

  task automatic test_timer();
    logic [31:0] v;
`ifdef MMIO_TIMER_EN
    logic [31:0] exp_wrap [4];
    exp_wrap[0] = 32'hFFFF_FFFE; exp_wrap[1] = 32'hFFFF_FFFF;
    exp_wrap[2] = 32'h0000_0000; exp_wrap[3] = 32'h0000_0001;
    wr_reg(5'h0C, 32'd5);
    wr_reg(5'h08, 32'd0);
    wr_reg(5'h00, 32'd3);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      tests_run++;
      if (bus.irq !== (k == 6)) begin tests_failed++;
        $display("FAIL timer_irq_cycle%0d: got %b want %b", k, bus.irq, (k == 6)); end
    end
    rd_reg(5'h04, v);
    tests_run++;
    if (v !== 32'h0000_0005) begin tests_failed++;
      $display("FAIL timer_match_status: got %h want %h", v, 32'h5); end
    wr_reg(5'h04, 32'h1);
    tests_run++;
    if (bus.irq !== 1'b0) begin tests_failed++;
      $display("FAIL timer_w1c_irq: got %b want 0", bus.irq); end
    rd_reg(5'h0C, v);
    tests_run++;
    if (v !== 32'd5) begin tests_failed++;
      $display("FAIL timer_compare_rd: got %h want %h", v, 32'd5); end
    wr_reg(5'h00, 32'h1);
    wr_reg(5'h08, 32'hFFFF_FFFE);
    for (int k = 0; k < 4; k++) begin
      rd_reg(5'h08, v);
      tests_run++;
      if (v !== exp_wrap[k]) begin tests_failed++;
        $display("FAIL timer_wrap%0d: got %h want %h", k, v, exp_wrap[k]); end
    end
    wr_reg(5'h08, 32'h0000_1234);
    rd_reg(5'h08, v);
    tests_run++;
    if (v !== 32'h0000_1234) begin tests_failed++;
      $display("FAIL timer_write_wins: got %h want %h", v, 32'h1234); end
    rd_reg(5'h08, v);
    tests_run++;
    if (v !== 32'h0000_1235) begin tests_failed++;
      $display("FAIL timer_after_write: got %h want %h", v, 32'h1235); end
    wr_reg(5'h00, 32'h0);
`else
    wr_reg(5'h0C, 32'd5);
    wr_reg(5'h08, 32'd7);
    wr_reg(5'h00, 32'd3);
    rd_reg(5'h00, v);
    tests_run++;
    if (v !== 32'h0000_0002) begin tests_failed++;
      $display("FAIL notimer_ctrl: got %h want %h", v, 32'h2); end
    rd_reg(5'h08, v);
    tests_run++;
    if (v !== 32'h0) begin tests_failed++;
      $display("FAIL notimer_count: got %h want %h", v, 32'h0); end
    rd_reg(5'h0C, v);
    tests_run++;
    if (v !== 32'h0) begin tests_failed++;
      $display("FAIL notimer_compare: got %h want %h", v, 32'h0); end
    repeat (10) @(negedge clk);
    rd_reg(5'h04, v);
    tests_run++;
    if (v !== 32'h0000_0004 || bus.irq !== 1'b0) begin tests_failed++;
      $display("FAIL notimer_status: got %h irq=%b want %h irq=0", v, bus.irq, 32'h4); end
    wr_reg(5'h00, 32'h0);
`endif
  endtask

  task automatic test_push_latency();
    bus.tx_ready = 1'b0;
    bus.addr = BASE + 32'h10; bus.wr = 1'b1; bus.wdata = 32'h0000_0077;
    #1;
    tests_run++;
    if (bus.tx_valid !== 1'b0) begin tests_failed++;
      $display("FAIL push_before_edge: got %b want 0", bus.tx_valid); end
    @(negedge clk);
    bus.wr = 1'b0; bus.addr = IDLE; bus.wdata = '0;
    tests_run++;
    if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'h77) begin tests_failed++;
      $display("FAIL push_after_edge: got valid=%b data=%h want 1 77", bus.tx_valid, bus.tx_data); end
    bus.tx_ready = 1'b1;
    @(negedge clk);
    bus.tx_ready = 1'b0;
    tests_run++;
    if (bus.tx_valid !== 1'b0) begin tests_failed++;
      $display("FAIL push_drained: got %b want 0", bus.tx_valid); end
  endtask

  task automatic test_fifo_overflow();
    logic [31:0] v;
    bus.tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) wr_reg(5'h10, 32'h41 + 32'(i));
    rd_reg(5'h04, v);
    tests_run++;
    if (v !== 32'h0000_004A) begin tests_failed++;
      $display("FAIL ovf_status: got %h want %h", v, 32'h4A); end
    tests_run++;
    if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'h41) begin tests_failed++;
      $display("FAIL ovf_head_hold: got valid=%b data=%h want 1 41", bus.tx_valid, bus.tx_data); end
    wr_reg(5'h04, 32'h8);
    rd_reg(5'h04, v);
    tests_run++;
    if (v !== 32'h0000_0042) begin tests_failed++;
      $display("FAIL ovf_w1c: got %h want %h", v, 32'h42); end
    bus.tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'(8'h41 + i)) begin tests_failed++;
        $display("FAIL ovf_drain%0d: got valid=%b data=%h want 1 %h",
                 i, bus.tx_valid, bus.tx_data, 8'(8'h41 + i)); end
      @(negedge clk);
    end
    bus.tx_ready = 1'b0;
    tests_run++;
    if (bus.tx_valid !== 1'b0) begin tests_failed++;
      $display("FAIL ovf_empty: got %b want 0", bus.tx_valid); end
  endtask

  task automatic test_full_push_pop();
    logic [31:0] v;
    bus.tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) wr_reg(5'h10, 32'h51 + 32'(i));
    bus.tx_ready = 1'b1;
    wr_reg(5'h10, 32'h55);
    bus.tx_ready = 1'b0;
    rd_reg(5'h04, v);
    tests_run++;
    if (v !== 32'h0000_0042) begin tests_failed++;
      $display("FAIL fullpop_status: got %h want %h", v, 32'h42); end
    bus.tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'(8'h52 + i)) begin tests_failed++;
        $display("FAIL fullpop_drain%0d: got valid=%b data=%h want 1 %h",
                 i, bus.tx_valid, bus.tx_data, 8'(8'h52 + i)); end
      @(negedge clk);
    end
    bus.tx_ready = 1'b0;
    tests_run++;
    if (bus.tx_valid !== 1'b0) begin tests_failed++;
      $display("FAIL fullpop_empty: got %b want 0", bus.tx_valid); end
  endtask

  task automatic test_window();
    logic [31:0] v;
    bus.addr = BASE + 32'h20; bus.wr = 1'b1; bus.wdata = 32'hFFFF_FFFF;
    #1;
    tests_run++;
    if (bus.hit !== 1'b0) begin tests_failed++;
      $display("FAIL window_hit_out: got %b want 0", bus.hit); end
    @(negedge clk);
    bus.wr = 1'b0;
    @(negedge clk);
    tests_run++;
    if (bus.rdata !== 32'h0) begin tests_failed++;
      $display("FAIL window_rdata_out: got %h want %h", bus.rdata, 32'h0); end
    bus.addr = BASE + 32'h1C;
    #1;
    tests_run++;
    if (bus.hit !== 1'b1) begin tests_failed++;
      $display("FAIL window_hit_in: got %b want 1", bus.hit); end
    @(negedge clk);
    bus.addr = IDLE;
    rd_reg(5'h00, v);
    tests_run++;
    if (v !== 32'h0) begin tests_failed++;
      $display("FAIL window_ctrl_unchanged: got %h want %h", v, 32'h0); end
    rd_reg(5'h04, v);
    tests_run++;
    if (v !== 32'h0000_0004 || bus.tx_valid !== 1'b0) begin tests_failed++;
      $display("FAIL window_status_unchanged: got %h valid=%b want %h 0", v, bus.tx_valid, 32'h4); end
    wr_reg(5'h10, 32'h99);
    rd_reg(5'h10, v);
    tests_run++;
    if (v !== 32'h0) begin tests_failed++;
      $display("FAIL window_txdata_rd: got %h want %h", v, 32'h0); end
    rd_reg(5'h14, v);
    tests_run++;
    if (v !== 32'h0) begin tests_failed++;
      $display("FAIL window_reserved_rd: got %h want %h", v, 32'h0); end
    bus.tx_ready = 1'b1;
    @(negedge clk);
    bus.tx_ready = 1'b0;
  endtask

  task automatic test_reset_midop();
    logic [31:0] v;
    bus.tx_ready = 1'b0;
    wr_reg(5'h10, 32'hA1);
    wr_reg(5'h10, 32'hA2);
    tests_run++;
    if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'hA1) begin tests_failed++;
      $display("FAIL midop_before: got valid=%b data=%h want 1 a1", bus.tx_valid, bus.tx_data); end
    #2;
    reset = 1'b0;
    #1;
    tests_run++;
    if (bus.tx_valid !== 1'b0 || bus.tx_data !== 8'h00 || bus.irq !== 1'b0) begin tests_failed++;
      $display("FAIL midop_async: got valid=%b data=%h irq=%b want 0 00 0",
               bus.tx_valid, bus.tx_data, bus.irq); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    rd_reg(5'h04, v);
    tests_run++;
    if (v !== 32'h0000_0004) begin tests_failed++;
      $display("FAIL midop_status: got %h want %h", v, 32'h4); end
  endtask

  initial begin
    test_reset();
    test_timer();
    test_push_latency();
    test_fifo_overflow();
    test_full_push_pop();
    test_window();
    test_reset_midop();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
